// File: rtl/ps2_keypad_if.sv
// PS/2 keypad bundle: raw pin inputs plus decoded key/code/error outputs.
// The slave side is the decoder; the master side drives the pins.
interface ps2_keypad_if #(
  parameter int NUM_KEYS = 5
);
  logic                ps2_clk;
  logic                ps2_data;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                code_valid;
  logic [7:0]          code_data;
  logic                code_ext;
  logic                code_break;
  logic                frame_err;
  logic [7:0]          err_count;

  modport master (
    output ps2_clk, ps2_data,
    input  key_held, key_press, key_release,
    input  code_valid, code_data, code_ext, code_break,
    input  frame_err, err_count
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output key_held, key_press, key_release,
    output code_valid, code_data, code_ext, code_break,
    output frame_err, err_count
  );
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 receiver with frame checking, stall watchdog, E0/F0 prefix
// decode and a parametrised scan-code to key table.
module ps2_keypad #(
  parameter int                    NUM_KEYS    = 5,
  parameter logic [9*NUM_KEYS-1:0] KEY_TABLE   = {9'h05A, 9'h023, 9'h01C,
                                                  9'h01B, 9'h01D},
  parameter int                    CLK_HZ      = 100_000_000,
  parameter int                    TIMEOUT_US  = 2000,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ps2_keypad_if.slave   kp
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WW     = $clog2(TO_CYC + 1);
  localparam logic [WW-1:0] TO_LAST = WW'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   cs_q, ds_q;
  logic                     cprev_q;
  logic [7:0]               shift_q;
  logic [2:0]               bit_q;
  logic                     par_ok_q;
  logic                     ext_q, brk_q;
  logic [WW-1:0]            wdog_q;
  logic [NUM_KEYS-1:0]      held_q, press_q, rel_q;
  logic                     cv_q, cext_q, cbrk_q, err_q;
  logic [7:0]               cdata_q, ecnt_q;

  logic                     clk_s, dat_s, fe_d;
  logic                     timeout_d, frame_ok_d, frame_bad_d;
  logic [NUM_KEYS-1:0]      match_d;

  assign clk_s = cs_q[SYNC_STAGES-1];
  assign dat_s = ds_q[SYNC_STAGES-1];
  assign fe_d  = cprev_q & ~clk_s;

  always_comb begin
    timeout_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_bad_d = 1'b0;
    match_d     = '0;
    // A falling edge in the expiry cycle still counts as progress.
    if (!fe_d && state_q != IDLE && wdog_q == TO_LAST)
      timeout_d = 1'b1;
    if (fe_d && state_q == STOP) begin
      if (par_ok_q && dat_s) frame_ok_d  = 1'b1;
      else                   frame_bad_d = 1'b1;
    end
    for (int i = 0; i < NUM_KEYS; i++)
      match_d[i] = (KEY_TABLE[9*i +: 9] == {ext_q, shift_q});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cs_q     <= '1;
      ds_q     <= '1;
      cprev_q  <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      par_ok_q <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wdog_q   <= '0;
      held_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      cv_q     <= 1'b0;
      cext_q   <= 1'b0;
      cbrk_q   <= 1'b0;
      err_q    <= 1'b0;
      cdata_q  <= '0;
      ecnt_q   <= '0;
    end else begin
      cs_q    <= {cs_q[SYNC_STAGES-2:0], kp.ps2_clk};
      ds_q    <= {ds_q[SYNC_STAGES-2:0], kp.ps2_data};
      cprev_q <= clk_s;
      press_q <= '0;
      rel_q   <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == IDLE || fe_d || timeout_d)
        wdog_q <= '0;
      else
        wdog_q <= wdog_q + 1'b1;

      if (timeout_d) begin
        state_q <= IDLE;
      end else if (fe_d) begin
        unique case (state_q)
          IDLE: if (!dat_s) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
          DATA: begin
            shift_q <= {dat_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_ok_q <= ^{shift_q, dat_s};
            state_q  <= STOP;
          end
          STOP: state_q <= IDLE;
        endcase
      end

      if (timeout_d || frame_bad_d) begin
        err_q <= 1'b1;
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 1'b1;
      end

      if (frame_ok_d) begin
        if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (shift_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else begin
          cv_q    <= 1'b1;
          cdata_q <= shift_q;
          cext_q  <= ext_q;
          cbrk_q  <= brk_q;
          ext_q   <= 1'b0;
          brk_q   <= 1'b0;
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (match_d[i]) begin
              if (!brk_q && !held_q[i]) begin
                held_q[i]  <= 1'b1;
                press_q[i] <= 1'b1;
              end else if (brk_q && held_q[i]) begin
                held_q[i] <= 1'b0;
                rel_q[i]  <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign kp.key_held    = held_q;
  assign kp.key_press   = press_q;
  assign kp.key_release = rel_q;
  assign kp.code_valid  = cv_q;
  assign kp.code_data   = cdata_q;
  assign kp.code_ext    = cext_q;
  assign kp.code_break  = cbrk_q;
  assign kp.frame_err   = err_q;
  assign kp.err_count   = ecnt_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad: table of frames with expected decode,
// plus timeout, mid-frame reset and error-counter saturation sequences.
module tb_ps2_keypad;

  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_keypad_if #(.NUM_KEYS(5)) kp ();

  ps2_keypad #(
    .NUM_KEYS   (5),
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (50),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.slave)
  );

  int checks   = 0;
  int failures = 0;

  int cv_n = 0, err_n = 0;
  int prs_n[5], rel_n[5];
  int cv_b, err_b;
  int prs_b[5], rel_b[5];

  initial begin
    for (int i = 0; i < 5; i++) begin
      prs_n[i] = 0;
      rel_n[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (kp.code_valid) cv_n++;
    if (kp.frame_err)  err_n++;
    for (int i = 0; i < 5; i++) begin
      if (kp.key_press[i])   prs_n[i]++;
      if (kp.key_release[i]) rel_n[i]++;
    end
  end

  typedef struct {
    logic [7:0] b;
    bit         bp;
    bit         bs;
    int         cv;
    logic [7:0] d;
    bit         ex;
    bit         br;
    logic [4:0] pr;
    logic [4:0] rl;
    logic [4:0] hd;
    int         er;
    logic [7:0] ec;
  } vec_t;

  vec_t v[19];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic snap();
    cv_b  = cv_n;
    err_b = err_n;
    for (int i = 0; i < 5; i++) begin
      prs_b[i] = prs_n[i];
      rel_b[i] = rel_n[i];
    end
  endtask

  function automatic logic [4:0] pmask();
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      if (prs_n[i] - prs_b[i] == 1) m[i] = 1'b1;
      else if (prs_n[i] != prs_b[i]) m[i] = 1'bx;
    return m;
  endfunction

  function automatic logic [4:0] rmask();
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++)
      if (rel_n[i] - rel_b[i] == 1) m[i] = 1'b1;
      else if (rel_n[i] != rel_b[i]) m[i] = 1'bx;
    return m;
  endfunction

  task automatic send_bit(input logic val);
    kp.ps2_data = val;
    repeat (H) @(negedge clk);
    kp.ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    kp.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp,
                            input bit bs);
    logic par;
    par = ~(^b) ^ bp;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bs);
    kp.ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, ".cv"},   64'(cv_n - cv_b),   64'(e.cv));
    chk({tag, ".data"}, 64'(kp.code_data),  64'(e.d));
    chk({tag, ".ext"},  64'(kp.code_ext),   64'(e.ex));
    chk({tag, ".brk"},  64'(kp.code_break), 64'(e.br));
    chk({tag, ".prs"},  64'(pmask()),       64'(e.pr));
    chk({tag, ".rel"},  64'(rmask()),       64'(e.rl));
    chk({tag, ".held"}, 64'(kp.key_held),   64'(e.hd));
    chk({tag, ".err"},  64'(err_n - err_b), 64'(e.er));
    chk({tag, ".ecnt"}, 64'(kp.err_count),  64'(e.ec));
  endtask

  function automatic logic [63:0] all_out();
    return 64'({kp.key_held, kp.key_press, kp.key_release,
                kp.code_valid, kp.code_data, kp.code_ext,
                kp.code_break, kp.frame_err, kp.err_count});
  endfunction

  initial begin
    vec_t e;
    v[0]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 5'h01, 5'h00, 5'h01, 0, 8'd0};
    v[1]  = '{8'hF0, 0, 0, 0, 8'h1D, 0, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[2]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 1, 5'h00, 5'h01, 5'h00, 0, 8'd0};
    v[3]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 5'h01, 5'h00, 5'h01, 0, 8'd0};
    v[4]  = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[5]  = '{8'hE0, 0, 0, 0, 8'h1D, 0, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[6]  = '{8'h75, 0, 0, 1, 8'h75, 1, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[7]  = '{8'hE0, 0, 0, 0, 8'h75, 1, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[8]  = '{8'hF0, 0, 0, 0, 8'h75, 1, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[9]  = '{8'h1D, 0, 0, 1, 8'h1D, 1, 1, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[10] = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 5'h00, 5'h00, 5'h01, 0, 8'd0};
    v[11] = '{8'h5A, 1, 0, 0, 8'h1D, 0, 0, 5'h00, 5'h00, 5'h01, 1, 8'd1};
    v[12] = '{8'h5A, 0, 0, 1, 8'h5A, 0, 0, 5'h10, 5'h00, 5'h11, 0, 8'd1};
    v[13] = '{8'hF0, 0, 0, 0, 8'h5A, 0, 0, 5'h00, 5'h00, 5'h11, 0, 8'd1};
    v[14] = '{8'h23, 0, 1, 0, 8'h5A, 0, 0, 5'h00, 5'h00, 5'h11, 1, 8'd2};
    v[15] = '{8'h1B, 0, 0, 1, 8'h1B, 0, 0, 5'h02, 5'h00, 5'h13, 0, 8'd2};
    v[16] = '{8'hE1, 0, 0, 1, 8'hE1, 0, 0, 5'h00, 5'h00, 5'h13, 0, 8'd2};
    v[17] = '{8'hF0, 0, 0, 0, 8'hE1, 0, 0, 5'h00, 5'h00, 5'h13, 0, 8'd2};
    v[18] = '{8'h5A, 0, 0, 1, 8'h5A, 0, 1, 5'h00, 5'h10, 5'h03, 0, 8'd2};

    kp.ps2_clk  = 1'b1;
    kp.ps2_data = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 19; k++) begin
      snap();
      send_frame(v[k].b, v[k].bp, v[k].bs);
      settle();
      chk_all($sformatf("vec%0d", k), v[k]);
    end

    // stall after four data bits
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (200) @(posedge clk);
    #1;
    chk("timeout.err",  64'(err_n - err_b), 64'd1);
    chk("timeout.ecnt", 64'(kp.err_count),  64'd3);
    chk("timeout.cv",   64'(cv_n - cv_b),   64'd0);
    snap();
    send_frame(8'h1C, 0, 0);
    settle();
    e = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 5'h04, 5'h00, 5'h07, 0, 8'd3};
    chk_all("after_timeout", e);

    // reset in the middle of a frame
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset.outputs", all_out(), 64'd0);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset.after", all_out(), 64'd0);
    chk("midreset.rel",   64'(rmask()), 64'd0);
    chk("midreset.err",   64'(err_n - err_b), 64'd0);

    // falling edge with data high in IDLE is not a start bit
    snap();
    send_bit(1'b1);
    settle();
    chk("idle_one.err", 64'(err_n - err_b), 64'd0);
    chk("idle_one.cv",  64'(cv_n - cv_b),   64'd0);

    snap();
    send_frame(8'h1D, 0, 0);
    settle();
    e = '{8'h1D, 0, 0, 1, 8'h1D, 0, 0, 5'h01, 5'h00, 5'h01, 0, 8'd0};
    chk_all("post_reset", e);

    snap();
    for (int n = 0; n < 300; n++) send_frame(8'h5A, 1, 0);
    settle();
    chk("sat.ecnt", 64'(kp.err_count),  64'hFF);
    chk("sat.err",  64'(err_n - err_b), 64'd300);
    chk("sat.cv",   64'(cv_n - cv_b),   64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
